// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: datapath defaults and forward-select codes.
package id_ex_operand_stage_pkg;

    localparam int unsigned DefaultXlen   = 32;
    localparam int unsigned DefaultRaddrW = 5;

    typedef enum logic [1:0] {
        FwdReg = 2'b00,
        FwdWb  = 2'b01,
        FwdMem = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_forward_mux.sv
// Per-operand bypass select: MEM result beats WB data beats the captured register value.
module id_ex_operand_stage_forward_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN    = DefaultXlen,
    parameter int unsigned RADDR_W = DefaultRaddrW
) (
    input  logic [RADDR_W-1:0] rs,
    input  logic [XLEN-1:0]    reg_data,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_result,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    op,
    output fwd_sel_e           sel
);

    // x0 is never bypassed so it always reads the captured zero.
    always_comb begin
        sel = FwdReg;
        op  = reg_data;
        if (rs != '0) begin
            if (mem_reg_write && (mem_rd == rs)) begin
                sel = FwdMem;
                op  = mem_result;
            end else if (wb_reg_write && (wb_rd == rs)) begin
                sel = FwdWb;
                op  = wb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall detection, flush squash and MEM/WB operand bypass.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN    = DefaultXlen,
    parameter int unsigned RADDR_W = DefaultRaddrW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               flush,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_result,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               id_stall,
    output logic               ex_valid,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_op1,
    output logic [XLEN-1:0]    ex_op2,
    output logic [1:0]         ex_fwd1,
    output logic [1:0]         ex_fwd2
);

    logic               valid_d,     valid_q;
    logic [RADDR_W-1:0] rs1_d,       rs1_q;
    logic [RADDR_W-1:0] rs2_d,       rs2_q;
    logic [RADDR_W-1:0] rd_d,        rd_q;
    logic               reg_write_d, reg_write_q;
    logic               mem_read_d,  mem_read_q;
    logic [XLEN-1:0]    pc_d,        pc_q;
    logic [XLEN-1:0]    imm_d,       imm_q;
    logic [XLEN-1:0]    rs1_data_d,  rs1_data_q;
    logic [XLEN-1:0]    rs2_data_d,  rs2_data_q;

    logic     load_use;
    fwd_sel_e fwd1_sel, fwd2_sel;

    assign load_use = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                      ((id_use_rs1 && (id_rs1 == rd_q)) || (id_use_rs2 && (id_rs2 == rd_q)));

    // A redirect makes the ID instruction dead, so there is nothing to hold.
    assign id_stall = load_use && !flush;

    always_comb begin
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        if (flush || id_stall) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else begin
            valid_d     = id_valid;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            reg_write_d = id_valid && id_reg_write;
            mem_read_d  = id_valid && id_mem_read;
            pc_d        = id_pc;
            imm_d       = id_imm;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
        end
    end

    id_ex_operand_stage_forward_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd1 (
        .rs            (rs1_q),
        .reg_data      (rs1_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .op            (ex_op1),
        .sel           (fwd1_sel)
    );

    id_ex_operand_stage_forward_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd2 (
        .rs            (rs2_q),
        .reg_data      (rs2_data_q),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .op            (ex_op2),
        .sel           (fwd2_sel)
    );

    assign ex_valid     = valid_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_pc        = pc_q;
    assign ex_imm       = imm_q;
    assign ex_fwd1      = fwd1_sel;
    assign ex_fwd2      = fwd2_sel;

endmodule
